// File: rtl/nanci_pkg.sv
// Shared types and elaboration helpers for the Nanci shearsort mesh.
// Covers the phase/state encodings, clog2, the schedule length and record field extraction.
package nanci_pkg;

    typedef enum logic {
        PhRow = 1'b0,
        PhCol = 1'b1
    } phase_e;

    typedef enum logic {
        StSort = 1'b0,
        StDone = 1'b1
    } state_e;

    function automatic int unsigned clog2(int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Shearsort needs clog2(side) row+column rounds and one final row sort.
    function automatic int unsigned num_phases(int unsigned sqrt_n);
        return 2 * clog2(sqrt_n) + 1;
    endfunction

    function automatic phase_e phase_of(logic lsb);
        return lsb ? PhCol : PhRow;
    endfunction

    // Records are at most 32 bits wide; fields come back zero-extended.
    function automatic logic [31:0] key_of(logic [31:0] rec, int unsigned data_width);
        return rec >> data_width;
    endfunction

    function automatic logic [31:0] data_of(logic [31:0] rec, int unsigned data_width);
        return rec & ((64'd1 << data_width) - 64'd1);
    endfunction

endpackage

// File: rtl/nanci_if.sv
// Record links between one processing element and its four mesh neighbours.
// The link also carries the key offset that is applied at reset.
interface nanci_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 3
);
    localparam int unsigned W = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] rst_memory;
    logic [W-1:0]          i_PE_l;
    logic [W-1:0]          i_PE_r;
    logic [W-1:0]          i_PE_u;
    logic [W-1:0]          i_PE_d;
    logic [W-1:0]          o_PE;

    modport master (
        input  rst_memory,
        input  i_PE_l,
        input  i_PE_r,
        input  i_PE_u,
        input  i_PE_d,
        output o_PE
    );

    modport slave (
        output rst_memory,
        output i_PE_l,
        output i_PE_r,
        output i_PE_u,
        output i_PE_d,
        input  o_PE
    );
endinterface

// File: rtl/nanci_cmp_swap.sv
// Combinational compare-exchange: keeps the smaller or larger keyed record.
// Equal keys always keep the PE's own record.
module nanci_cmp_swap
    import nanci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 3
) (
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] own_i,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] partner_i,
    input  logic                             keep_max_i,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] result_o
);
    logic [31:0] own_key;
    logic [31:0] partner_key;
    logic        take_partner;

    always_comb begin
        own_key      = key_of(32'(own_i), DATA_WIDTH);
        partner_key  = key_of(32'(partner_i), DATA_WIDTH);
        take_partner = keep_max_i ? (partner_key > own_key) : (partner_key < own_key);
        result_o     = take_partner ? partner_i : own_i;
    end
endmodule

// File: rtl/nanci_pe.sv
// One processing element of the Nanci shearsort mesh: holds a {key,data} record
// and compare-exchanges it with a neighbour chosen by the row/column schedule.
module nanci_pe
    import nanci_pkg::*;
#(
    parameter int unsigned N            = 1,
    parameter int unsigned SQRT_N       = 0,
    parameter int unsigned I            = 0,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned SORT_CYCLES  = 1,
    parameter int unsigned FIRST_IN_ROW = 0,
    // Init table: entry k sits at bits [k*W +: W]; this PE loads entry I.
    parameter logic [(I+1)*(ADDR_WIDTH+DATA_WIDTH)-1:0] INIT_MEM = '0
) (
    input logic     clk,
    input logic     rst,
    nanci_if.master pe
);
    localparam int unsigned W         = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned Side      = (SQRT_N < 2) ? 1 : SQRT_N;
    localparam int unsigned Row       = I / Side;
    localparam int unsigned Col       = I % Side;
    localparam bit          Lone      = (SQRT_N < 2) || (N < 4);
    localparam bit          HasL      = !Lone && (Col != 0) && (FIRST_IN_ROW == 0);
    localparam bit          HasR      = !Lone && (Col + 1 < Side);
    localparam bit          HasU      = !Lone && (Row != 0);
    localparam bit          HasD      = !Lone && (Row + 1 < Side);
    localparam bit          RowOdd    = (Row % 2) == 1;
    localparam bit          ColOdd    = (Col % 2) == 1;
    localparam int unsigned NumPhases = num_phases(SQRT_N);
    localparam int unsigned PhW       = clog2(NumPhases) + 1;
    localparam int unsigned StW       = clog2(SORT_CYCLES) + 1;

    localparam logic [W-1:0]          InitRec  = INIT_MEM[I*W +: W];
    localparam logic [ADDR_WIDTH-1:0] InitKey  = InitRec[W-1:DATA_WIDTH];
    localparam logic [DATA_WIDTH-1:0] InitData = InitRec[DATA_WIDTH-1:0];

    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [StW-1:0] step_q, step_d;
    logic [W-1:0]   rec_q, rec_d;
    logic [W-1:0]   reset_rec;
    logic [W-1:0]   partner_rec;
    logic [W-1:0]   swap_rec;
    logic           has_partner;
    logic           keep_max;
    logic           s;

    assign reset_rec = {InitKey + pe.rst_memory, InitData};
    assign pe.o_PE   = rec_q;

    // Partner and role: the lower position of a pair keeps the smaller key.
    always_comb begin
        s           = step_q[0];
        partner_rec = pe.i_PE_r;
        has_partner = 1'b0;
        keep_max    = 1'b0;
        if (phase_of(phase_q[0]) == PhRow) begin
            if (ColOdd == s) begin
                partner_rec = pe.i_PE_r;
                has_partner = HasR;
                keep_max    = RowOdd;
            end else begin
                partner_rec = pe.i_PE_l;
                has_partner = HasL;
                keep_max    = !RowOdd;
            end
        end else begin
            if (RowOdd == s) begin
                partner_rec = pe.i_PE_d;
                has_partner = HasD;
                keep_max    = 1'b0;
            end else begin
                partner_rec = pe.i_PE_u;
                has_partner = HasU;
                keep_max    = 1'b1;
            end
        end
    end

    nanci_cmp_swap #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp_swap (
        .own_i     (rec_q),
        .partner_i (partner_rec),
        .keep_max_i(keep_max),
        .result_o  (swap_rec)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        rec_d   = rec_q;
        unique case (state_q)
            StSort: begin
                if (has_partner) rec_d = swap_rec;
                if (step_q == StW'(SORT_CYCLES - 1)) begin
                    step_d = '0;
                    if (phase_q == PhW'(NumPhases - 1)) state_d = StDone;
                    else                                 phase_d = phase_q + 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: ;
            default: state_d = StDone;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StSort;
            phase_q <= '0;
            step_q  <= '0;
            rec_q   <= reset_rec;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            rec_q   <= rec_d;
        end
    end
endmodule

// File: tb/tb_nanci_pe.sv
// Self-checking bench for nanci_pe: lone PE, single exchanges on a 2x2 mesh
// position, and a full 4x4 mesh sorted into snake order against a sort model.
module tb_nanci_pe;
    import nanci_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    // Lone PE, I=5; entry 5 is 000101, other entries are decoys.
    localparam logic [35:0] InitL = {6'b000101, 6'b111010, 6'b110011,
                                     6'b101100, 6'b011110, 6'b100111};
    localparam logic [5:0]  InitA = 6'b011001;
    localparam logic [17:0] InitB = {6'b001001, 6'b111111, 6'b101010};

    nanci_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3)) bus_l ();
    nanci_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3)) bus_a ();
    nanci_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3)) bus_b ();

    nanci_pe #(.N(1), .SQRT_N(0), .I(5), .ADDR_WIDTH(3), .DATA_WIDTH(3),
               .SORT_CYCLES(1), .FIRST_IN_ROW(1), .INIT_MEM(InitL))
        u_lone (.clk(clk), .rst(rst), .pe(bus_l));

    nanci_pe #(.N(4), .SQRT_N(2), .I(0), .ADDR_WIDTH(3), .DATA_WIDTH(3),
               .SORT_CYCLES(2), .FIRST_IN_ROW(1), .INIT_MEM(InitA))
        u_pe_a (.clk(clk), .rst(rst), .pe(bus_a));

    nanci_pe #(.N(4), .SQRT_N(2), .I(2), .ADDR_WIDTH(3), .DATA_WIDTH(3),
               .SORT_CYCLES(2), .FIRST_IN_ROW(1), .INIT_MEM(InitB))
        u_pe_b (.clk(clk), .rst(rst), .pe(bus_b));

    // 4x4 mesh: entry k = {k, k}; keys are randomised through rst_memory.
    function automatic logic [127:0] mk_table();
        logic [127:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[k*8 +: 8] = {4'(k), 4'(k)};
        return t;
    endfunction

    localparam logic [127:0] MeshTable = mk_table();

    logic [7:0] mesh_rec [16];
    logic [3:0] mesh_off [16];

    for (genvar k = 0; k < 16; k++) begin : g_mesh
        localparam int R = k / 4;
        localparam int C = k % 4;
        nanci_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus ();
        assign bus.rst_memory = mesh_off[k];
        assign bus.i_PE_l     = (C > 0) ? mesh_rec[(k + 15) % 16] : 8'h5A;
        assign bus.i_PE_r     = (C < 3) ? mesh_rec[(k + 1) % 16]  : 8'h0F;
        assign bus.i_PE_u     = (R > 0) ? mesh_rec[(k + 12) % 16] : 8'hF0;
        assign bus.i_PE_d     = (R < 3) ? mesh_rec[(k + 4) % 16]  : 8'h00;
        assign mesh_rec[k]    = bus.o_PE;
        nanci_pe #(.N(16), .SQRT_N(4), .I(k), .ADDR_WIDTH(4), .DATA_WIDTH(4),
                   .SORT_CYCLES(4), .FIRST_IN_ROW((C == 0) ? 1 : 0),
                   .INIT_MEM(MeshTable[(k+1)*8-1:0]))
            u_pe (.clk(clk), .rst(rst), .pe(bus));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] keep(logic [5:0] own, logic [5:0] partner, bit want_max);
        if (want_max) return (partner[5:3] > own[5:3]) ? partner : own;
        return (partner[5:3] < own[5:3]) ? partner : own;
    endfunction

    task automatic test_reset();
        bus_l.rst_memory = 3'b000;
        bus_a.rst_memory = 3'b000;
        bus_b.rst_memory = 3'b000;
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus_l.o_PE !== 6'b000101) begin
            n_fail++; $display("FAIL reset_lone: got %b expected %b", bus_l.o_PE, 6'b000101);
        end
        n_tests++;
        if (bus_a.o_PE !== InitA) begin
            n_fail++; $display("FAIL reset_a: got %b expected %b", bus_a.o_PE, InitA);
        end
        n_tests++;
        if (bus_b.o_PE !== 6'b001001) begin
            n_fail++; $display("FAIL reset_b: got %b expected %b", bus_b.o_PE, 6'b001001);
        end
    endtask

    task automatic test_lone();
        logic [2:0] offs [2];
        offs[0] = 3'b000;
        offs[1] = 3'b010;
        for (int t = 0; t < 6; t++) begin
            logic [2:0] off;
            logic [5:0] exp;
            off = (t < 2) ? offs[t] : 3'($urandom_range(0, 7));
            exp = {off, 3'b101};
            bus_l.rst_memory = off;
            rst = 1'b0;
            tick();
            rst = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (t == 0) begin
                    bus_l.i_PE_l = 6'b001000; bus_l.i_PE_r = 6'b010000;
                    bus_l.i_PE_u = 6'b011000; bus_l.i_PE_d = 6'b100000;
                end else begin
                    bus_l.i_PE_l = 6'($urandom); bus_l.i_PE_r = 6'($urandom);
                    bus_l.i_PE_u = 6'($urandom); bus_l.i_PE_d = 6'($urandom);
                end
                tick();
            end
            n_tests++;
            if (bus_l.o_PE !== exp) begin
                n_fail++; $display("FAIL lone_hold[%0d]: got %b expected %b", t, bus_l.o_PE, exp);
            end
        end
    endtask

    // want_max selects B (odd row keeps larger key), otherwise A (even row keeps smaller).
    task automatic test_row_exchange(bit use_b, int iters);
        for (int t = 0; t < iters; t++) begin
            logic [2:0] off;
            logic [5:0] own, partner, exp;
            off = (t == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            own = use_b ? {3'(3'b001 + off), 3'b001} : {3'(3'b011 + off), 3'b001};
            partner = (t == 0) ? (use_b ? 6'b011000 : 6'b001110) : 6'($urandom);
            if (use_b) bus_b.rst_memory = off; else bus_a.rst_memory = off;
            rst = 1'b0;
            tick();
            rst = 1'b1;
            if (use_b) begin
                bus_b.i_PE_r = partner; bus_b.i_PE_l = 6'($urandom);
                bus_b.i_PE_u = 6'($urandom); bus_b.i_PE_d = 6'($urandom);
            end else begin
                bus_a.i_PE_r = partner; bus_a.i_PE_l = 6'($urandom);
                bus_a.i_PE_u = 6'($urandom); bus_a.i_PE_d = 6'($urandom);
            end
            tick();
            exp = keep(own, partner, use_b);
            n_tests++;
            if ((use_b ? bus_b.o_PE : bus_a.o_PE) !== exp) begin
                n_fail++;
                $display("FAIL row_step0_%s[%0d]: got %b expected %b", use_b ? "odd" : "even", t,
                         use_b ? bus_b.o_PE : bus_a.o_PE, exp);
            end
            // Step 1 pairs this column-0 PE leftwards: nothing there, so it holds.
            if (use_b) bus_b.i_PE_r = 6'($urandom); else bus_a.i_PE_r = 6'($urandom);
            tick();
            n_tests++;
            if ((use_b ? bus_b.o_PE : bus_a.o_PE) !== exp) begin
                n_fail++;
                $display("FAIL row_step1_hold[%0d]: got %b expected %b", t,
                         use_b ? bus_b.o_PE : bus_a.o_PE, exp);
            end
        end
    endtask

    task automatic test_equal_keys();
        bus_a.rst_memory = 3'b111;  // 011 + 111 -> key 010
        bus_b.rst_memory = 3'b001;  // 001 + 001 -> key 010
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus_a.i_PE_r = 6'b010111;
        bus_b.i_PE_r = 6'b010111;
        tick();
        n_tests++;
        if (bus_a.o_PE !== 6'b010001) begin
            n_fail++; $display("FAIL equal_a: got %b expected %b", bus_a.o_PE, 6'b010001);
        end
        n_tests++;
        if (bus_b.o_PE !== 6'b010001) begin
            n_fail++; $display("FAIL equal_b: got %b expected %b", bus_b.o_PE, 6'b010001);
        end
    endtask

    task automatic randomize_mesh();
        for (int k = 0; k < 16; k++) mesh_off[k] = 4'($urandom_range(0, 15));
    endtask

    task automatic check_mesh_reset(string tag);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] exp;
            exp = {4'(4'(k) + mesh_off[k]), 4'(k)};
            n_tests++;
            if (mesh_rec[k] !== exp) begin
                n_fail++; $display("FAIL %s[%0d]: got %h expected %h", tag, k, mesh_rec[k], exp);
            end
        end
    endtask

    task automatic check_sorted(string tag);
        logic [7:0] exp_recs[$];
        logic [7:0] act_recs[$];
        logic [3:0] keys[$];
        for (int k = 0; k < 16; k++) begin
            logic [3:0] key;
            key = 4'(k) + mesh_off[k];
            keys.push_back(key);
            exp_recs.push_back({key, 4'(k)});
        end
        keys.sort();
        exp_recs.sort();
        for (int p = 0; p < 16; p++) begin
            int r, c, idx;
            r   = p / 4;
            c   = p % 4;
            idx = (r % 2 == 0) ? r * 4 + c : r * 4 + 3 - c;
            n_tests++;
            if (mesh_rec[idx][7:4] !== keys[p]) begin
                n_fail++;
                $display("FAIL %s_snake[%0d]: got key %h expected %h", tag, p, mesh_rec[idx][7:4],
                         keys[p]);
            end
            act_recs.push_back(mesh_rec[idx]);
        end
        act_recs.sort();
        for (int p = 0; p < 16; p++) begin
            n_tests++;
            if (act_recs[p] !== exp_recs[p]) begin
                n_fail++;
                $display("FAIL %s_records[%0d]: got %h expected %h", tag, p, act_recs[p],
                         exp_recs[p]);
            end
        end
    endtask

    task automatic test_mesh_sort(int runs);
        for (int t = 0; t < runs; t++) begin
            randomize_mesh();
            rst = 1'b0;
            tick();
            check_mesh_reset("mesh_reset");
            rst = 1'b1;
            repeat (22) tick();
            check_sorted("mesh_done");
            repeat (10) tick();
            check_sorted("mesh_stable");
        end
    endtask

    task automatic test_mid_sort_reset();
        randomize_mesh();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (7) tick();
        randomize_mesh();
        rst = 1'b0;
        tick();
        check_mesh_reset("mid_reset");
        rst = 1'b1;
        repeat (22) tick();
        check_sorted("mid_resort");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst     = 1'b0;
        bus_l.rst_memory = '0; bus_l.i_PE_l = '0; bus_l.i_PE_r = '0;
        bus_l.i_PE_u     = '0; bus_l.i_PE_d = '0;
        bus_a.rst_memory = '0; bus_a.i_PE_l = '0; bus_a.i_PE_r = '0;
        bus_a.i_PE_u     = '0; bus_a.i_PE_d = '0;
        bus_b.rst_memory = '0; bus_b.i_PE_l = '0; bus_b.i_PE_r = '0;
        bus_b.i_PE_u     = '0; bus_b.i_PE_d = '0;
        for (int k = 0; k < 16; k++) mesh_off[k] = '0;
        @(negedge clk);
        test_reset();
        test_lone();
        test_row_exchange(1'b0, 8);
        test_row_exchange(1'b1, 8);
        test_equal_keys();
        test_mesh_sort(6);
        test_mid_sort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
